// File: rtl/max_unpooling.sv
// 2x nearest-neighbour upsampler: each pooled pixel is emitted twice per row,
// and each row is replayed from a line buffer to double the height.
module max_unpooling #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned IMG_WIDTH  = 32,
    parameter int unsigned IMG_HEIGHT = 32
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic [DATA_WIDTH-1:0] DATA_IN,
    input  logic                  data_valid_in,
    output logic                  din_ready,
    output logic [DATA_WIDTH-1:0] DATA_OUT,
    output logic                  data_valid_out,
    input  logic                  dout_ready,
    output logic                  frame_done
);

    localparam int unsigned OW = IMG_WIDTH / 2;
    localparam int unsigned OH = IMG_HEIGHT / 2;
    localparam int unsigned CW = (OW > 1) ? $clog2(OW) : 1;
    localparam int unsigned RW = (OH > 1) ? $clog2(OH) : 1;

    typedef enum logic {
        PASS0,
        PASS1
    } state_t;

    state_t                state;
    logic [CW-1:0]         col;
    logic [RW-1:0]         row;
    logic                  phase;
    logic [DATA_WIDTH-1:0] line_buf [OW];

    logic slot_free;
    logic accept;
    logic last_col;
    logic last_row;

    assign slot_free = !data_valid_out || dout_ready;
    assign din_ready = RST_N && (state == PASS0) && !phase && slot_free;
    assign accept    = data_valid_in && din_ready;
    assign last_col  = (col == CW'(OW - 1));
    assign last_row  = (row == RW'(OH - 1));

    // Row buffer holds the live row for its replay; contents need no reset.
    always_ff @(posedge CLK) begin
        if (accept) begin
            line_buf[col] <= DATA_IN;
        end
    end

    // Pass sequencer: live pass with pixel doubling, then buffered replay.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state          <= PASS0;
            col            <= '0;
            row            <= '0;
            phase          <= 1'b0;
            DATA_OUT       <= '0;
            data_valid_out <= 1'b0;
            frame_done     <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (slot_free) begin
                case (state)
                    PASS0: begin
                        if (!phase) begin
                            if (data_valid_in) begin
                                DATA_OUT       <= DATA_IN;
                                data_valid_out <= 1'b1;
                                phase          <= 1'b1;
                            end else begin
                                data_valid_out <= 1'b0;
                            end
                        end else begin
                            data_valid_out <= 1'b1;
                            phase          <= 1'b0;
                            if (last_col) begin
                                col   <= '0;
                                state <= PASS1;
                            end else begin
                                col <= col + CW'(1);
                            end
                        end
                    end
                    PASS1: begin
                        DATA_OUT       <= line_buf[col];
                        data_valid_out <= 1'b1;
                        phase          <= !phase;
                        if (phase) begin
                            if (last_col) begin
                                col   <= '0;
                                state <= PASS0;
                                if (last_row) begin
                                    row        <= '0;
                                    frame_done <= 1'b1;
                                end else begin
                                    row <= row + RW'(1);
                                end
                            end else begin
                                col <= col + CW'(1);
                            end
                        end
                    end
                    default: state <= PASS0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_max_unpooling.sv
// Bench for max_unpooling: index-mapping reference model checked every cycle,
// plus directed sequences with literal expected outputs.
module tb_max_unpooling;

    localparam int unsigned DW = 8;
    localparam int W  = 4;
    localparam int H  = 4;
    localparam int OW = W / 2;
    localparam int OH = H / 2;
    localparam int F  = W * H;

    logic          CLK;
    logic          RST_N;
    logic [DW-1:0] DATA_IN;
    logic          data_valid_in;
    logic          din_ready;
    logic [DW-1:0] DATA_OUT;
    logic          data_valid_out;
    logic          dout_ready;
    logic          frame_done;

    max_unpooling #(
        .DATA_WIDTH(DW),
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H)
    ) dut (
        .CLK           (CLK),
        .RST_N         (RST_N),
        .DATA_IN       (DATA_IN),
        .data_valid_in (data_valid_in),
        .din_ready     (din_ready),
        .DATA_OUT      (DATA_OUT),
        .data_valid_out(data_valid_out),
        .dout_ready    (dout_ready),
        .frame_done    (frame_done)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int vectors    = 0;
    int miscompares = 0;

    logic [DW-1:0] inputs [$];
    logic [DW-1:0] obs [$];
    int            xfers     = 0;
    logic          prev_free = 1'b1;
    logic [DW-1:0] prev_data = '0;
    int            fd_count  = 0;
    int            fd_at     = -1;
    logic          tog       = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_first_copy(input int n);
        int k;
        k = n % F;
        return ((k / W) % 2 == 0) && ((k % W) % 2 == 0);
    endfunction

    function automatic int src_index(input int n);
        int f, k;
        f = n / F;
        k = n % F;
        return f * OW * OH + ((k / W) / 2) * OW + (k % W) / 2;
    endfunction

    // Output stream model: position in frame determines source pixel and timing rules.
    always @(negedge CLK) begin
        logic free;
        int   idx;
        if (!RST_N) begin
            chk("rst_data_out", 32'(DATA_OUT), 32'd0);
            chk("rst_valid_out", 32'(data_valid_out), 32'd0);
            chk("rst_frame_done", 32'(frame_done), 32'd0);
            chk("rst_din_ready", 32'(din_ready), 32'd0);
            inputs.delete();
            xfers     = 0;
            prev_free = 1'b1;
        end else begin
            free = !data_valid_out || dout_ready;
            chk("din_ready", 32'(din_ready),
                32'(free && is_first_copy(xfers + int'(data_valid_out))));
            chk("frame_done", 32'(frame_done),
                32'(data_valid_out && prev_free && ((xfers % F) == F - 1)));
            if (!is_first_copy(xfers)) begin
                chk("valid_continuous", 32'(data_valid_out), 32'd1);
            end
            if (!prev_free) begin
                chk("hold_data", 32'(DATA_OUT), 32'(prev_data));
                chk("hold_valid", 32'(data_valid_out), 32'd1);
            end
            if (frame_done) begin
                fd_count++;
                fd_at = obs.size();
            end
            if (data_valid_in && din_ready) begin
                inputs.push_back(DATA_IN);
            end
            if (data_valid_out && dout_ready) begin
                idx = src_index(xfers);
                if (idx >= inputs.size()) begin
                    chk("data_out_src", 32'(idx), 32'(inputs.size()));
                end else begin
                    chk("data_out", 32'(DATA_OUT), 32'(inputs[idx]));
                end
                obs.push_back(DATA_OUT);
                xfers++;
            end
            prev_free = free;
            prev_data = DATA_OUT;
        end
    end

    // Downstream ready: constant 1, or alternating when tog is set.
    always @(posedge CLK) begin
        #1;
        dout_ready = tog ? ~dout_ready : 1'b1;
    end

    // Present one pixel until accepted; returns at posedge+1 with obs size at accept.
    task automatic send(input logic [DW-1:0] p, input int gap, output int acc_obs);
        logic acc;
        acc_obs = -1;
        DATA_IN       = p;
        data_valid_in = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge CLK);
            #1;
            acc     = din_ready;
            acc_obs = obs.size();
            @(posedge CLK);
            #1;
            if (acc) break;
            if (i == 199) chk("send_timeout", 32'd0, 32'd1);
        end
        data_valid_in = 1'b0;
        repeat (gap) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic wait_obs(input int n);
        for (int i = 0; i < 300 && obs.size() < n; i++) begin
            @(posedge CLK);
            #1;
        end
        chk("obs_count", 32'(obs.size()), 32'(n));
    endtask

    task automatic clear_obs();
        obs.delete();
        fd_count = 0;
        fd_at    = -1;
    endtask

    task automatic check_seq(input string name, input int exp [], input int offset);
        for (int i = 0; i < exp.size(); i++) begin
            if (offset + i < obs.size()) begin
                chk(name, 32'(obs[offset + i]), 32'(exp[i]));
            end else begin
                chk(name, 32'hFFFF_FFFF, 32'(exp[i]));
            end
        end
    endtask

    initial begin
        int a;
        int seq_a [] = '{1,1,2,2,1,1,2,2,3,3,4,4,3,3,4,4};
        int seq_b [] = '{5,5,6,6,5,5,6,6,7,7,8,8,7,7,8,8};
        int seq_r [] = '{9,9,8,8,9,9,8,8,7,7,6,6,7,7,6,6};

        RST_N         = 1'b0;
        DATA_IN       = '0;
        data_valid_in = 1'b0;
        dout_ready    = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        RST_N = 1'b1;
        clear_obs();

        // Continuous input, ready held high
        send(8'd1, 0, a); chk("t1_acc1", 32'(a), 32'd0);
        send(8'd2, 0, a); chk("t1_acc2", 32'(a), 32'd2);
        send(8'd3, 0, a); chk("t1_acc3_after_replay", 32'(a), 32'd8);
        send(8'd4, 0, a); chk("t1_acc4", 32'(a), 32'd10);
        wait_obs(16);
        check_seq("t1_seq", seq_a, 0);
        chk("t1_fd_count", 32'(fd_count), 32'd1);
        chk("t1_fd_at", 32'(fd_at), 32'd15);

        // Alternating downstream ready
        repeat (2) @(posedge CLK);
        #1;
        clear_obs();
        tog = 1'b1;
        for (int i = 1; i <= 4; i++) send(DW'(i), 0, a);
        wait_obs(16);
        tog = 1'b0;
        check_seq("t2_seq", seq_a, 0);
        chk("t2_fd_count", 32'(fd_count), 32'd1);

        // Input gap between pixels 1 and 2
        repeat (4) @(posedge CLK);
        #1;
        clear_obs();
        send(8'd1, 3, a);
        send(8'd2, 0, a); chk("t3_acc2", 32'(a), 32'd2);
        send(8'd3, 0, a);
        send(8'd4, 0, a);
        wait_obs(16);
        check_seq("t3_seq", seq_a, 0);
        chk("t3_fd_count", 32'(fd_count), 32'd1);

        // Reset mid-row, then a fresh frame
        repeat (2) @(posedge CLK);
        #1;
        clear_obs();
        send(8'd1, 0, a);
        send(8'd2, 0, a);
        wait_obs(3);
        @(posedge CLK);
        #1;
        RST_N = 1'b0;
        #1;
        chk("t5_async_data", 32'(DATA_OUT), 32'd0);
        chk("t5_async_valid", 32'(data_valid_out), 32'd0);
        repeat (2) @(posedge CLK);
        #1;
        RST_N = 1'b1;
        clear_obs();
        send(8'd9, 0, a); chk("t5_acc9", 32'(a), 32'd0);
        send(8'd8, 0, a);
        send(8'd7, 0, a);
        send(8'd6, 0, a);
        wait_obs(16);
        check_seq("t5_seq", seq_r, 0);
        chk("t5_fd_count", 32'(fd_count), 32'd1);

        // Two back-to-back frames
        repeat (2) @(posedge CLK);
        #1;
        clear_obs();
        for (int i = 1; i <= 4; i++) send(DW'(i), 0, a);
        send(8'd5, 0, a); chk("t6_acc5", 32'(a), 32'd16);
        for (int i = 6; i <= 8; i++) send(DW'(i), 0, a);
        wait_obs(32);
        check_seq("t6_seq_f1", seq_a, 0);
        check_seq("t6_seq_f2", seq_b, 16);
        chk("t6_fd_count", 32'(fd_count), 32'd2);
        chk("t6_fd_at", 32'(fd_at), 32'd31);

        repeat (3) @(posedge CLK);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
